icmp_tx_checksum_inserter: RTL and testbench

Transmit-side ICMP checksum generator for the Ethernet TX path. Accepts a complete ICMP message (type byte onward) as a byte stream, stores it in an internal buffer while computing the RFC 1071 one's-complement sum, then replays the message with bytes 2–3 (checksum field) replaced by the computed checksum. It sits between the ICMP reply builder and the IPv4 header/frame assembler, mirroring the receive-side checksum check.

---
 rtl/icmp_tx_checksum_inserter.sv | 155 +++++++++++++++
 tb/tb_icmp_tx_checksum_inserter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_tx_checksum_inserter.sv
// ICMP transmit checksum inserter: buffers one message while folding the RFC 1071
// sum, then replays it with bytes 2-3 replaced by the one's-complement checksum.
//
// state | meaning
// IDLE  | waiting for a byte with sop; other bytes are dropped
// RECV  | storing bytes, accumulating the 16-bit end-around-carry sum
// FOLD  | latching ~sum as the checksum, reading byte 0
// SEND  | streaming the buffer with the checksum substituted
module icmp_tx_checksum_inserter #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_sop,
    input  logic       i_eop,
    output logic       o_in_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_sop,
    output logic       o_eop,
    input  logic       i_ready,
    output logic       o_err,
    output logic       o_busy
);
    typedef enum logic [1:0] {IDLE, RECV, FOLD, SEND} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t      state, state_nxt;
    logic [7:0]  mem [0:DEPTH-1];
    logic [AW:0] count, len, rd_addr;
    logic [15:0] sum, cksum;
    logic [7:0]  hi;

    logic        acc, start, take, take_eop, in_range, len_bad, add_en;
    logic        pop, load;
    logic [AW:0] idx, rd_sel;
    logic [15:0] word, sum_base, sum_add;
    logic [16:0] t;

    // Receive-side decode and the one's-complement adder.
    always_comb begin
        acc      = i_valid & o_in_ready;
        start    = acc & i_sop;
        take     = start | (acc & (state == RECV));
        take_eop = take & i_eop;
        idx      = start ? '0 : count;
        in_range = idx < DEPTH_W;
        len_bad  = (idx < (AW+1)'(3)) || !in_range;
        add_en   = idx[0] | i_eop;
        word     = idx[0] ? {hi, i_data} : {i_data, 8'h00};
        if (idx == (AW+1)'(2) || idx == (AW+1)'(3)) begin
            word = '0;
        end
        sum_base = start ? '0 : sum;
        t        = {1'b0, sum_base} + {1'b0, word};
        sum_add  = t[15:0] + {15'd0, t[16]};
        pop      = o_valid & i_ready;
        load     = (state == FOLD) | ((state == SEND) & pop & ~o_eop);
        rd_sel   = (state == FOLD) ? '0 : rd_addr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RECV: begin
                if (take && i_eop) begin
                    state_nxt = len_bad ? IDLE : FOLD;
                end else if (take) begin
                    state_nxt = RECV;
                end
            end
            FOLD:    state_nxt = SEND;
            SEND:    if (pop && o_eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = i_reset_n && (state == IDLE || state == RECV);
        o_busy     = (state != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (take && in_range) begin
            mem[idx[AW-1:0]] <= i_data;
        end
    end

    // Count saturates at DEPTH so an overlong message is caught on its eop.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count <= '0;
            sum   <= '0;
            hi    <= '0;
            len   <= '0;
        end else if (take) begin
            count <= in_range ? idx + ONE_W : idx;
            sum   <= add_en ? sum_add : sum_base;
            if (!idx[0]) begin
                hi <= i_data;
            end
            if (i_eop) begin
                len <= idx + ONE_W;
            end
        end
    end

    // Read data lands straight in the output register, which holds while stalled.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            o_err   <= 1'b0;
            rd_addr <= '0;
            cksum   <= '0;
        end else begin
            o_err <= take_eop & len_bad;
            if (state == FOLD) begin
                cksum <= ~sum;
            end
            if (load) begin
                o_valid <= 1'b1;
                o_sop   <= (rd_sel == '0);
                o_eop   <= (rd_sel == len - ONE_W);
                rd_addr <= rd_sel + ONE_W;
                if (rd_sel == (AW+1)'(2)) begin
                    o_data <= cksum[15:8];
                end else if (rd_sel == (AW+1)'(3)) begin
                    o_data <= cksum[7:0];
                end else begin
                    o_data <= mem[rd_sel[AW-1:0]];
                end
            end else if (pop) begin
                o_valid <= 1'b0;
                o_sop   <= 1'b0;
                o_eop   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_icmp_tx_checksum_inserter.sv
// Directed bench for icmp_tx_checksum_inserter: hand-computed checksums,
// latency, backpressure, error drops and reset abort.
module tb_icmp_tx_checksum_inserter;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_sop = 1'b0;
    logic       i_eop = 1'b0;
    logic       i_ready = 1'b1;
    logic       o_in_ready, o_valid, o_sop, o_eop, o_err, o_busy;
    logic [7:0] o_data;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int eop_cyc, first_cyc, rx_n, stall_bad, stalls;
    bit done, err_seen, any_valid;

    logic [7:0] tx_buf [0:DEPTH+15];
    logic [7:0] exp_buf [0:15];
    logic [7:0] rx_buf [0:15];
    logic       rx_sop [0:15];
    logic       rx_eop [0:15];

    icmp_tx_checksum_inserter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_valid(i_valid), .i_data(i_data), .i_sop(i_sop), .i_eop(i_eop),
        .o_in_ready(o_in_ready),
        .o_valid(o_valid), .o_data(o_data), .o_sop(o_sop), .o_eop(o_eop),
        .i_ready(i_ready), .o_err(o_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic load_tx(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) tx_buf[i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic load_exp(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) exp_buf[i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic send_seq(input int n, input bit with_eop);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_data  = tx_buf[i];
            i_sop   = (i == 0);
            i_eop   = with_eop && (i == n - 1);
            if (i == n - 1) eop_cyc = cyc;
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
    endtask

    task automatic collect(input int budget, input bit bp);
        logic [3:0] pat;
        logic       held_v, held_s, held_e;
        logic [7:0] held_d;
        pat = 4'b1001;
        held_v = 1'b0; held_s = 1'b0; held_e = 1'b0; held_d = 8'h00;
        rx_n = 0; done = 0; first_cyc = -1; stall_bad = 0; stalls = 0;
        err_seen = 0; any_valid = 0;
        for (int i = 0; i < 16; i++) begin
            rx_buf[i] = 'x; rx_sop[i] = 'x; rx_eop[i] = 'x;
        end
        for (int k = 0; k < budget && !done; k++) begin
            i_ready = bp ? pat[k % 4] : 1'b1;
            if (o_err) err_seen = 1;
            if (o_valid) begin
                any_valid = 1;
                if (first_cyc < 0) first_cyc = cyc;
                if (held_v && ({o_data, o_sop, o_eop} !== {held_d, held_s, held_e})) stall_bad++;
                if (i_ready) begin
                    if (rx_n < 16) begin
                        rx_buf[rx_n] = o_data; rx_sop[rx_n] = o_sop; rx_eop[rx_n] = o_eop;
                    end
                    rx_n++;
                    held_v = 1'b0;
                    if (o_eop) done = 1;
                end else begin
                    held_v = 1'b1; held_d = o_data; held_s = o_sop; held_e = o_eop;
                    stalls++;
                end
            end
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_assert++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", o_in_ready); end
        n_assert++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_assert++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_data); end
        n_assert++; if ({o_sop, o_eop, o_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {o_sop, o_eop, o_err}); end
        n_assert++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        n_assert++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", o_in_ready); end
    endtask

    task automatic test_echo();
        load_tx(80'h0000AABB000100016162, 10);
        load_exp(80'h00009E9B000100016162, 10);
        send_seq(10, 1'b1);
        n_assert++; if ({o_in_ready, o_busy, o_valid} !== 3'b010) begin n_fail++; $display("FAIL echo_fold: got rdy/busy/valid %b want 010", {o_in_ready, o_busy, o_valid}); end
        collect(40, 1'b0);
        n_assert++; if (first_cyc != eop_cyc + 2) begin n_fail++; $display("FAIL echo_latency: got cycle %0d want %0d", first_cyc, eop_cyc + 2); end
        n_assert++; if (!done || rx_n != 10) begin n_fail++; $display("FAIL echo_len: got %0d bytes done=%0b want 10", rx_n, done); end
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (rx_buf[i] !== exp_buf[i] || rx_sop[i] !== (i == 0) || rx_eop[i] !== (i == 9)) begin
                n_fail++; $display("FAIL echo_byte%0d: got %h sop=%b eop=%b want %h", i, rx_buf[i], rx_sop[i], rx_eop[i], exp_buf[i]);
            end
        end
        n_assert++; if ({o_in_ready, o_busy} !== 2'b10) begin n_fail++; $display("FAIL echo_ready_return: got rdy/busy %b want 10", {o_in_ready, o_busy}); end
    endtask

    task automatic test_odd_len();
        load_tx(56'h00000000123456, 7);
        load_exp(56'h000097CB123456, 7);
        send_seq(7, 1'b1);
        collect(40, 1'b0);
        n_assert++; if (!done || rx_n != 7) begin n_fail++; $display("FAIL odd_len: got %0d bytes done=%0b want 7", rx_n, done); end
        for (int i = 0; i < 7; i++) begin
            n_assert++;
            if (rx_buf[i] !== exp_buf[i] || rx_sop[i] !== (i == 0) || rx_eop[i] !== (i == 6)) begin
                n_fail++; $display("FAIL odd_byte%0d: got %h sop=%b eop=%b want %h", i, rx_buf[i], rx_sop[i], rx_eop[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_carry_wrap();
        load_tx(64'h00001122FFFFFFFF, 8);
        load_exp(64'h00000000FFFFFFFF, 8);
        send_seq(8, 1'b1);
        collect(40, 1'b0);
        n_assert++; if (!done || rx_n != 8) begin n_fail++; $display("FAIL carry_len: got %0d bytes done=%0b want 8", rx_n, done); end
        for (int i = 0; i < 8; i++) begin
            n_assert++;
            if (rx_buf[i] !== exp_buf[i]) begin
                n_fail++; $display("FAIL carry_byte%0d: got %h want %h", i, rx_buf[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        load_tx(48'h080000000001, 6);
        load_exp(48'h0800F7FE0001, 6);
        send_seq(6, 1'b1);
        collect(60, 1'b1);
        n_assert++; if (!done || rx_n != 6) begin n_fail++; $display("FAIL bp_len: got %0d bytes done=%0b want 6", rx_n, done); end
        n_assert++; if (stalls == 0 || stall_bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d stalls %0d unstable want >0 stalls 0 unstable", stalls, stall_bad); end
        for (int i = 0; i < 6; i++) begin
            n_assert++;
            if (rx_buf[i] !== exp_buf[i] || rx_sop[i] !== (i == 0) || rx_eop[i] !== (i == 5)) begin
                n_fail++; $display("FAIL bp_byte%0d: got %h sop=%b eop=%b want %h", i, rx_buf[i], rx_sop[i], rx_eop[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_errors();
        // Too short
        load_tx(24'h000000, 3);
        send_seq(3, 1'b1);
        n_assert++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b want 1", o_err); end
        @(posedge i_clk); #1;
        n_assert++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL short_err_pulse: got %b want 0", o_err); end
        collect(12, 1'b0);
        n_assert++; if (any_valid) begin n_fail++; $display("FAIL short_output: got %0d bytes want 0", rx_n); end
        // Too long
        for (int i = 0; i <= DEPTH; i++) tx_buf[i] = 8'(i);
        send_seq(DEPTH + 1, 1'b1);
        n_assert++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL long_err: got %b want 1", o_err); end
        collect(12, 1'b0);
        n_assert++; if (any_valid) begin n_fail++; $display("FAIL long_output: got %0d bytes want 0", rx_n); end
        // Restart by a second sop
        load_tx(40'h0000123456, 5);
        send_seq(5, 1'b0);
        load_tx(80'h0000AABB000100016162, 10);
        load_exp(80'h00009E9B000100016162, 10);
        send_seq(10, 1'b1);
        n_assert++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL restart_err: got %b want 0", o_err); end
        collect(40, 1'b0);
        n_assert++; if (err_seen || !done || rx_n != 10) begin n_fail++; $display("FAIL restart_len: got %0d bytes err=%0b want 10 err=0", rx_n, err_seen); end
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (rx_buf[i] !== exp_buf[i]) begin
                n_fail++; $display("FAIL restart_byte%0d: got %h want %h", i, rx_buf[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_idle_discard();
        i_valid = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_data = 8'h5A;
        repeat (2) @(posedge i_clk);
        i_eop = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_eop = 1'b0;
        n_assert++; if ({o_busy, o_err} !== 2'b00) begin n_fail++; $display("FAIL discard_state: got busy/err %b want 00", {o_busy, o_err}); end
        collect(8, 1'b0);
        n_assert++; if (any_valid || err_seen) begin n_fail++; $display("FAIL discard_output: got %0d bytes err=%0b want 0", rx_n, err_seen); end
    endtask

    task automatic test_reset_mid_send();
        load_tx(48'h080000000001, 6);
        send_seq(6, 1'b1);
        repeat (2) @(posedge i_clk);
        #1;
        n_assert++; if ({o_valid, o_busy} !== 2'b11) begin n_fail++; $display("FAIL midrst_sending: got valid/busy %b want 11", {o_valid, o_busy}); end
        i_reset_n = 1'b0;
        @(posedge i_clk); #1;
        n_assert++; if ({o_valid, o_busy, o_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_abort: got valid/busy/err %b want 000", {o_valid, o_busy, o_err}); end
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        load_tx(48'h080000001234, 6);
        load_exp(48'h0800E5CB1234, 6);
        send_seq(6, 1'b1);
        collect(40, 1'b0);
        n_assert++; if (!done || rx_n != 6) begin n_fail++; $display("FAIL midrst_len: got %0d bytes done=%0b want 6", rx_n, done); end
        for (int i = 0; i < 6; i++) begin
            n_assert++;
            if (rx_buf[i] !== exp_buf[i]) begin
                n_fail++; $display("FAIL midrst_byte%0d: got %h want %h", i, rx_buf[i], exp_buf[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_odd_len();
        test_carry_wrap();
        test_backpressure();
        test_errors();
        test_idle_discard();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule
